// File: rtl/pe_types.sv
// Shared types and constants for the PE-array input path.
package pe_types;

    // PE array configuration; data_w selects the width of one array input word.
    typedef struct packed {
        int unsigned data_w;
    } pe_cfg_t;

    localparam pe_cfg_t pe_cfg_top = '{data_w: 32'd16};

    localparam int unsigned PE_IN_FIFO_DEPTH_DEFAULT = 8;

    // Occupancy statistics exported by pe_in_fifo when PE_IN_FIFO_STATS_EN is defined.
    typedef struct packed {
        logic [31:0] acc_count;
        logic [31:0] drop_count;
    } pe_in_fifo_stats_t;

endpackage

// File: rtl/pe_sat_cnt.sv
// Saturating 32-bit event counter with a synchronous clear.
module pe_sat_cnt (
    input  logic        clock,
    input  logic        reset,
    input  logic        inc,
    output logic [31:0] count
);

    logic [31:0] count_q;
    logic [31:0] count_d;

    // Advance on each event, holding at all-ones once reached.
    always_comb begin
        count_d = count_q;
        if (inc && (count_q != '1)) begin
            count_d = count_q + 32'd1;
        end
    end

    // Counter register with synchronous clear.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pe_in_fifo.sv
// First-word-fall-through input FIFO in front of the PE array.
// Sources may ignore iready: words arriving while full (and not draining)
// are dropped and the sticky overflow flag is raised.
// Optional feature macro: PE_IN_FIFO_STATS_EN adds acc_count/drop_count outputs.
module pe_in_fifo
    import pe_types::*;
#(
    parameter pe_cfg_t     cfg   = pe_cfg_top,
    parameter int unsigned DEPTH = PE_IN_FIFO_DEPTH_DEFAULT,
    parameter int unsigned SLACK = 2
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         ivalid,
    output logic                         iready,
    input  logic [cfg.data_w-1:0]        idata,
    output logic                         ovalid,
    input  logic                         oready,
    output logic [cfg.data_w-1:0]        odata,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         overflow
`ifdef PE_IN_FIFO_STATS_EN
    ,
    output logic [31:0]                  acc_count,
    output logic [31:0]                  drop_count
`endif
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = $clog2(DEPTH + 1);
    localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0] LVL_READY = LVL_W'(DEPTH - SLACK);

    logic [cfg.data_w-1:0] mem_q [DEPTH];
    logic [cfg.data_w-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]      level_q, level_d;
    logic                  overflow_q, overflow_d;

    logic push;
    logic pop;
    logic drop;

    // Handshake decode: a pop frees a slot so a push is legal even when full.
    always_comb begin
        pop  = (level_q != '0) && oready;
        push = ivalid && ((level_q < LVL_FULL) || pop);
        drop = ivalid && !push;
    end

    // Pointer, occupancy and sticky overflow next-state.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        overflow_d = overflow_q | drop;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    // Control registers with synchronous reset; reset discards any concurrent push.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage write: only the slot under the write pointer changes.
    always_comb begin
        mem_d = mem_q;
        if (push && !reset) begin
            mem_d[wr_ptr_q] = idata;
        end
    end

    // Storage array; contents need no reset since level gates visibility.
    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

    assign iready   = (level_q < LVL_READY);
    assign ovalid   = (level_q != '0);
    assign odata    = mem_q[rd_ptr_q];
    assign level    = level_q;
    assign overflow = overflow_q;

`ifdef PE_IN_FIFO_STATS_EN
    pe_in_fifo_stats_t stats;
    logic [31:0]       acc_cnt;
    logic [31:0]       drop_cnt;

    pe_sat_cnt u_acc_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (push),
        .count (acc_cnt)
    );

    pe_sat_cnt u_drop_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (drop),
        .count (drop_cnt)
    );

    assign stats      = '{acc_count: acc_cnt, drop_count: drop_cnt};
    assign acc_count  = stats.acc_count;
    assign drop_count = stats.drop_count;
`endif

endmodule

// File: tb/tb_pe_in_fifo.sv
// Scoreboard bench for pe_in_fifo (DEPTH=8, SLACK=2): directed scenarios then a random soak.
module tb_pe_in_fifo;
    import pe_types::*;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned SLACK = 2;
    localparam int unsigned DW    = pe_cfg_top.data_w;
    localparam int unsigned LW    = $clog2(DEPTH + 1);

    logic          clock = 1'b0;
    logic          reset;
    logic          ivalid;
    logic          iready;
    logic [DW-1:0] idata;
    logic          ovalid;
    logic          oready;
    logic [DW-1:0] odata;
    logic [LW-1:0] level;
    logic          overflow;
`ifdef PE_IN_FIFO_STATS_EN
    logic [31:0]   acc_count;
    logic [31:0]   drop_count;
`endif

    int checks   = 0;
    int failures = 0;

    // Reference state: the words the FIFO must hold, in order, plus flag/counters.
    logic [DW-1:0]   exp_q[$];
    bit              m_ovf;
    longint unsigned m_acc;
    longint unsigned m_drop;
    int unsigned     max_level;
    bit              track;

    pe_in_fifo #(
        .cfg   (pe_cfg_top),
        .DEPTH (DEPTH),
        .SLACK (SLACK)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .ivalid   (ivalid),
        .iready   (iready),
        .idata    (idata),
        .ovalid   (ovalid),
        .oready   (oready),
        .odata    (odata),
        .level    (level),
        .overflow (overflow)
`ifdef PE_IN_FIFO_STATS_EN
        ,
        .acc_count  (acc_count),
        .drop_count (drop_count)
`endif
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input longint unsigned act, input longint unsigned req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic push_words(input int unsigned first, input int unsigned count);
        for (int unsigned i = 0; i < count; i++) begin
            ivalid = 1'b1;
            idata  = DW'(first + i);
            step();
        end
        ivalid = 1'b0;
    endtask

    task automatic drain(input string name);
        int unsigned budget;
        budget = 0;
        oready = 1'b1;
        while (level != '0 && budget < 40) begin
            step();
            budget++;
        end
        check({name, "_drain_done"}, level, 0);
    endtask

    initial begin
        reset  = 1'b1;
        ivalid = 1'b0;
        oready = 1'b0;
        idata  = '0;
        m_ovf  = 1'b0;
        m_acc  = 0;
        m_drop = 0;
        track  = 1'b0;
        max_level = 0;

        fork
            // Monitor and reference model, sampled on the falling edge.
            forever begin
                int unsigned n;
                bit mpop;
                bit mpush;
                @(negedge clock);
                n = exp_q.size();
                check("ovalid", ovalid, (n != 0) ? 1 : 0);
                check("level", level, n);
                check("iready", iready, (n < DEPTH - SLACK) ? 1 : 0);
                check("overflow", overflow, m_ovf);
`ifdef PE_IN_FIFO_STATS_EN
                check("acc_count", acc_count, m_acc);
                check("drop_count", drop_count, m_drop);
`endif
                if (!track) max_level = 0;
                else if (level > max_level) max_level = level;
                // The array takes a word: it must be the oldest one accepted.
                if (ovalid && oready) begin
                    if (n == 0) check("underrun", 1, 0);
                    else        check("odata", odata, exp_q[0]);
                end
                // Advance the reference to the state after the coming edge.
                if (reset) begin
                    exp_q.delete();
                    m_ovf  = 1'b0;
                    m_acc  = 0;
                    m_drop = 0;
                end else begin
                    mpop  = (n != 0) && oready;
                    mpush = ivalid && ((n < DEPTH) || mpop);
                    if (mpop) void'(exp_q.pop_front());
                    if (mpush) begin
                        exp_q.push_back(idata);
                        if (m_acc < 64'hFFFF_FFFF) m_acc++;
                    end else if (ivalid) begin
                        m_ovf = 1'b1;
                        if (m_drop < 64'hFFFF_FFFF) m_drop++;
                    end
                end
            end
            begin
                #5_000_000;
                failures++;
                $display("FAIL watchdog actual=timeout required=finish");
                $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
                $fatal(1, "watchdog");
            end
        join_none

        step();
        step();
        reset = 1'b0;

        // Basic flow with the array always ready.
        oready = 1'b1;
        track  = 1'b1;
        push_words(1, 5);
        step();
        step();
        check("basic_peak_level", max_level, 1);
        check("basic_overflow", overflow, 0);
        track = 1'b0;

        // Threshold: fill to 6 with the array stalled.
        oready = 1'b0;
        push_words(100, 6);
        check("thresh_level", level, 6);
        check("thresh_iready", iready, 0);
        drain("thresh");

        // Overflow: 10 words into an 8-entry FIFO, source ignoring iready.
        reset = 1'b1;
        step();
        reset  = 1'b0;
        oready = 1'b0;
        push_words(1, 10);
        check("ovf_level", level, 8);
        check("ovf_flag", overflow, 1);
`ifdef PE_IN_FIFO_STATS_EN
        check("ovf_drop_count", drop_count, 2);
        check("ovf_acc_count", acc_count, 8);
`endif

        // Full with simultaneous push and pop across the pointer wrap.
        oready = 1'b1;
        push_words(11, 4);
        oready = 1'b0;
        check("full_pp_level", level, 8);
`ifdef PE_IN_FIFO_STATS_EN
        check("full_pp_drop_count", drop_count, 2);
`endif
        drain("full_pp");

        // Reset mid-stream while a word is offered.
        reset = 1'b1;
        step();
        reset  = 1'b0;
        oready = 1'b0;
        push_words(200, 5);
        check("mid_level_before", level, 5);
        reset  = 1'b1;
        ivalid = 1'b1;
        idata  = DW'(999);
        step();
        reset  = 1'b0;
        ivalid = 1'b0;
        check("mid_ovalid", ovalid, 0);
        check("mid_level", level, 0);
        check("mid_overflow", overflow, 0);
        check("mid_iready", iready, 1);
        push_words(42, 1);
        check("mid_first_word", odata, 42);
        drain("mid");

        // Random soak with a source that honours iready.
        track = 1'b1;
        for (int unsigned c = 0; c < 10000; c++) begin
            ivalid = ($urandom_range(99) < 50) && iready;
            idata  = DW'($urandom);
            oready = ($urandom_range(99) < 30);
            step();
        end
        ivalid = 1'b0;
        check("soak_max_level", (max_level <= 7) ? 1 : 0, 1);
        check("soak_overflow", overflow, 0);
        track = 1'b0;
        drain("soak");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
